chip_dma_slot_arbiter: RTL and testbench

//  Per-colour-clock chip-bus slot scheduler for the A1000 Agnus model.

---
 rtl/chip_dma_slot_arbiter_pkg.sv | 28 ++
 rtl/chip_dma_slot_arbiter_bpl_fetch_window.sv | 29 ++
 rtl/chip_dma_slot_arbiter.sv | 92 +++++++++
 tb/tb_chip_dma_slot_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/chip_dma_slot_arbiter_pkg.sv
// chip_dma_pkg: slot owner codes, fixed-slot positions, DMACON bit indices and lowres plane order
package chip_dma_pkg;
  typedef enum logic [3:0] {
    OWN_FREE = 4'd0, OWN_REF = 4'd1, OWN_DSK = 4'd2, OWN_AUD = 4'd3, OWN_SPR = 4'd4,
    OWN_BPL = 4'd5, OWN_COP = 4'd6, OWN_BLT = 4'd7, OWN_CPU = 4'd8
  } owner_e;
  localparam int LINE_LEN = 227;
  localparam int NASTY_MAX = 3;
  localparam logic [7:0] HP_LAST = 8'(LINE_LEN - 1);
  localparam logic [7:0] HP_REF_LAST = 8'h07;
  localparam logic [7:0] HP_DSK_FIRST = 8'h09;
  localparam logic [7:0] HP_DSK_LAST = 8'h0D;
  localparam logic [7:0] HP_AUD_FIRST = 8'h0F;
  localparam logic [7:0] HP_AUD_LAST = 8'h15;
  localparam logic [7:0] HP_SPR_FIRST = 8'h17;
  localparam logic [7:0] HP_SPR_LAST = 8'h35;
  localparam int DMAEN_B = 9;
  localparam int BPLEN_B = 8;
  localparam int COPEN_B = 7;
  localparam int BLTEN_B = 6;
  localparam int SPREN_B = 5;
  localparam int DSKEN_B = 4;
  // Plane number fetched at each offset of an 8-slot unit, offset 0 in the low bits; 0 = no fetch
  localparam logic [23:0] PLANE_ORDER = {3'd1, 3'd5, 3'd3, 3'd0, 3'd2, 3'd6, 3'd4, 3'd0};
  function automatic logic [2:0] plane_of(input logic [2:0] off);
    return PLANE_ORDER[int'(off) * 3 +: 3];
  endfunction
endpackage

// File: rtl/chip_dma_slot_arbiter_bpl_fetch_window.sv
// bpl_fetch_window: decides whether a slot is a bitplane fetch and which plane
//   i_hpos slot being decoded, i_ddfstrt/i_ddfstop fetch window, i_bpu depth, i_en DMAEN&BPLEN
//   o_take slot is a bitplane fetch, o_ix plane number minus one
import chip_dma_pkg::*;
module bpl_fetch_window (
  input  logic [7:0] i_hpos,
  input  logic [7:0] i_ddfstrt,
  input  logic [7:0] i_ddfstop,
  input  logic [2:0] i_bpu,
  input  logic       i_en,
  output logic       o_take,
  output logic [2:0] o_ix
);
  logic [7:0] w_strt;
  logic [8:0] w_end;
  logic       w_in;
  logic [2:0] w_off;
  logic [2:0] w_plane;
  logic [2:0] w_depth;
  assign w_strt = {i_ddfstrt[7:1], 1'b0};
  assign w_end = {1'b0, i_ddfstop} + 9'd8;
  // A stop before the start leaves the window empty
  assign w_in = i_ddfstop >= w_strt && i_hpos >= w_strt && {1'b0, i_hpos} < w_end;
  assign w_off = 3'(i_hpos - w_strt);
  assign w_plane = plane_of(w_off);
  assign w_depth = (i_bpu == 3'd7) ? 3'd6 : i_bpu;
  assign o_take = i_en && w_in && w_plane != 3'd0 && w_plane <= w_depth;
  assign o_ix = w_plane - 3'd1;
endmodule

// File: rtl/chip_dma_slot_arbiter.sv
// chip_dma_slot_arbiter: horizontal slot counter granting each chip-bus slot to one owner
//   i_cck clock, i_rst sync reset, i_dmacon enables, i_bltpri blitter-nasty,
//   i_ddfstrt/i_ddfstop/i_bpu bitplane fetch, i_*_req requests;
//   o_hpos slot, o_owner/o_owner_ix slot owner, o_*_gnt grant pulses, o_line_stb last slot
import chip_dma_pkg::*;
module chip_dma_slot_arbiter (
  input  logic        i_cck,
  input  logic        i_rst,
  input  logic [10:0] i_dmacon,
  input  logic        i_bltpri,
  input  logic [7:0]  i_ddfstrt,
  input  logic [7:0]  i_ddfstop,
  input  logic [2:0]  i_bpu,
  input  logic        i_dsk_req,
  input  logic [3:0]  i_aud_req,
  input  logic        i_cop_req,
  input  logic        i_blt_req,
  input  logic        i_cpu_req,
  output logic [7:0]  o_hpos,
  output logic [3:0]  o_owner,
  output logic [2:0]  o_owner_ix,
  output logic        o_cpu_gnt,
  output logic        o_blt_gnt,
  output logic        o_cop_gnt,
  output logic        o_line_stb
);
  logic [7:0] r_hpos;
  owner_e     r_owner;
  logic [2:0] r_ix;
  logic       r_cpu_gnt, r_blt_gnt, r_cop_gnt, r_line_stb;
  logic [1:0] r_nasty;
  logic [7:0] w_nh;
  logic       w_dma, w_ref, w_dsk, w_aud, w_spr, w_cop, w_blt, w_force, w_bpl;
  logic [1:0] w_aud_x;
  logic [2:0] w_spr_n, w_bpl_ix, w_ix;
  logic [1:0] w_nasty;
  owner_e     w_owner;
  // Everything is decoded for the slot about to be shown, so outputs line up with o_hpos
  assign w_nh = (r_hpos == HP_LAST) ? 8'd0 : r_hpos + 8'd1;
  assign w_dma = i_dmacon[DMAEN_B];
  assign w_ref = w_nh[0] && w_nh <= HP_REF_LAST;
  assign w_dsk = w_nh[0] && w_nh >= HP_DSK_FIRST && w_nh <= HP_DSK_LAST &&
                 w_dma && i_dmacon[DSKEN_B] && i_dsk_req;
  assign w_aud_x = 2'((w_nh - HP_AUD_FIRST) >> 1);
  assign w_aud = w_nh[0] && w_nh >= HP_AUD_FIRST && w_nh <= HP_AUD_LAST &&
                 w_dma && i_dmacon[w_aud_x] && i_aud_req[w_aud_x];
  assign w_spr_n = 3'((w_nh - HP_SPR_FIRST) >> 2);
  assign w_spr = w_nh[0] && w_nh >= HP_SPR_FIRST && w_nh <= HP_SPR_LAST && w_dma && i_dmacon[SPREN_B];
  assign w_cop = !w_nh[0] && w_dma && i_dmacon[COPEN_B] && i_cop_req;
  assign w_blt = w_dma && i_dmacon[BLTEN_B] && i_blt_req;
  // After NASTY_MAX stolen slots the waiting CPU gets the next free one
  assign w_force = !i_bltpri && r_nasty == 2'(NASTY_MAX) && i_cpu_req;
  bpl_fetch_window u_bpl (
    .i_hpos(w_nh), .i_ddfstrt(i_ddfstrt), .i_ddfstop(i_ddfstop), .i_bpu(i_bpu),
    .i_en(w_dma && i_dmacon[BPLEN_B]), .o_take(w_bpl), .o_ix(w_bpl_ix)
  );
  assign w_owner = w_ref ? OWN_REF : w_dsk ? OWN_DSK : w_aud ? OWN_AUD : w_bpl ? OWN_BPL :
                   w_spr ? OWN_SPR : w_cop ? OWN_COP : (w_blt && !w_force) ? OWN_BLT :
                   i_cpu_req ? OWN_CPU : OWN_FREE;
  assign w_ix = (w_owner == OWN_AUD) ? {1'b0, w_aud_x} : (w_owner == OWN_BPL) ? w_bpl_ix :
                (w_owner == OWN_SPR) ? w_spr_n : 3'd0;
  assign w_nasty = (i_bltpri || w_owner == OWN_CPU) ? 2'd0 :
                   (w_owner == OWN_BLT && i_cpu_req) ? r_nasty + 2'd1 : r_nasty;
  always_ff @(posedge i_cck) begin
    if (i_rst) begin
      r_hpos <= 8'd0;
      r_owner <= OWN_FREE;
      r_ix <= 3'd0;
      r_cpu_gnt <= 1'b0;
      r_blt_gnt <= 1'b0;
      r_cop_gnt <= 1'b0;
      r_line_stb <= 1'b0;
      r_nasty <= 2'd0;
    end else begin
      r_hpos <= w_nh;
      r_owner <= w_owner;
      r_ix <= w_ix;
      r_cpu_gnt <= w_owner == OWN_CPU;
      r_blt_gnt <= w_owner == OWN_BLT;
      r_cop_gnt <= w_owner == OWN_COP;
      r_line_stb <= w_nh == HP_LAST;
      r_nasty <= w_nasty;
    end
  end
  assign o_hpos = r_hpos;
  assign o_owner = r_owner;
  assign o_owner_ix = r_ix;
  assign o_cpu_gnt = r_cpu_gnt;
  assign o_blt_gnt = r_blt_gnt;
  assign o_cop_gnt = r_cop_gnt;
  assign o_line_stb = r_line_stb;
endmodule

// File: tb/tb_chip_dma_slot_arbiter.sv
// tb_chip_dma_slot_arbiter: slot-rule model plus directed literal checks
module tb_chip_dma_slot_arbiter;
  logic clk = 0, rst = 1;
  logic [10:0] dmacon = 0;
  logic bltpri = 0;
  logic [7:0] strt = 8'h38, stop = 8'hD0;
  logic [2:0] bpu = 3'd6;
  logic dsk_req = 0, cop_req = 0, blt_req = 0, cpu_req = 1;
  logic [3:0] aud_req = 0;
  logic [7:0] hpos;
  logic [3:0] owner;
  logic [2:0] oix;
  logic cg, bg, pg, stb;
  int checks = 0, errors = 0;
  int m_h, m_own, m_ix, m_nasty;
  bit m_stb, m_valid = 0;

  chip_dma_slot_arbiter dut (
    .i_cck(clk), .i_rst(rst), .i_dmacon(dmacon), .i_bltpri(bltpri), .i_ddfstrt(strt),
    .i_ddfstop(stop), .i_bpu(bpu), .i_dsk_req(dsk_req), .i_aud_req(aud_req),
    .i_cop_req(cop_req), .i_blt_req(blt_req), .i_cpu_req(cpu_req), .o_hpos(hpos),
    .o_owner(owner), .o_owner_ix(oix), .o_cpu_gnt(cg), .o_blt_gnt(bg), .o_cop_gnt(pg),
    .o_line_stb(stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at hpos=%0d t=%0t", nm, act, exp, hpos, $time);
    end
  endtask

  // Owner codes: 0 free 1 ref 2 dsk 3 aud 4 spr 5 bpl 6 cop 7 blt 8 cpu
  function automatic void slot_rules(input int h, input int nasty, output int own, output int ix,
                                     output int nn);
    int order[8] = '{0, 4, 6, 2, 0, 3, 5, 1};
    int s = int'(strt) & 'hFE;
    int depth = (bpu == 7) ? 6 : int'(bpu);
    int plane;
    bit dma = dmacon[9];
    bit blt, force_cpu;
    own = 0; ix = 0; nn = nasty;
    if (h inside {1, 3, 5, 7}) own = 1;
    else if (h inside {9, 11, 13} && dma && dmacon[4] && dsk_req) own = 2;
    for (int x = 0; x < 4; x++)
      if (own == 0 && h == 15 + 2 * x && dma && dmacon[x] && aud_req[x]) begin own = 3; ix = x; end
    if (own == 0 && dma && dmacon[8] && int'(stop) >= s && h >= s && h < int'(stop) + 8) begin
      plane = order[(h - s) % 8];
      if (plane != 0 && plane <= depth) begin own = 5; ix = plane - 1; end
    end
    for (int n = 0; n < 8; n++)
      if (own == 0 && (h == 23 + 4 * n || h == 25 + 4 * n) && dma && dmacon[5]) begin own = 4; ix = n; end
    if (own == 0 && h % 2 == 0 && dma && dmacon[7] && cop_req) own = 6;
    if (own == 0) begin
      blt = dma && dmacon[6] && blt_req;
      force_cpu = !bltpri && nasty == 3 && cpu_req;
      if (blt && !force_cpu) begin own = 7; if (cpu_req && !bltpri) nn = nasty + 1; end
      else if (cpu_req) begin own = 8; nn = 0; end
    end
    if (bltpri) nn = 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_h = 0; m_own = 0; m_ix = 0; m_nasty = 0; m_stb = 0; m_valid = 1;
    end else if (m_valid) begin
      int nh, o, x, n;
      nh = (m_h == 226) ? 0 : m_h + 1;
      slot_rules(nh, m_nasty, o, x, n);
      m_h = nh; m_own = o; m_ix = x; m_nasty = n; m_stb = (nh == 226);
    end
  end

  always @(posedge clk) begin
    #2;
    if (m_valid) begin
      chk("hpos", hpos, m_h);
      chk("owner", owner, m_own);
      chk("owner_ix", oix, m_ix);
      chk("cpu_gnt", cg, int'(m_own == 8));
      chk("blt_gnt", bg, int'(m_own == 7));
      chk("cop_gnt", pg, int'(m_own == 6));
      chk("line_stb", stb, int'(m_stb));
    end
  end

  task automatic wait_slot(input int h);
    int n = 0;
    while (int'(hpos) != h && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) chk("wait_slot_timeout", n, 0);
  endtask

  task automatic lit(input string nm, input int h, input int o, input int x);
    wait_slot(h);
    chk({nm, "_owner"}, owner, o);
    chk({nm, "_ix"}, oix, x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int cnt, bcnt;
    int lh[12] = '{9, 15, 21, 23, 53, 56, 57, 58, 60, 63, 215, 216};
    int lo[12] = '{2, 3, 3, 4, 4, 6, 5, 5, 6, 5, 5, 6};
    int lx[12] = '{0, 0, 3, 0, 7, 0, 3, 5, 0, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk("rst_hpos", hpos, 0);
    chk("rst_owner", owner, 0);
    chk("rst_gnt", {cg, bg, pg, stb}, 0);
    rst = 0;
    @(negedge clk);
    chk("first_hpos", hpos, 1);
    chk("first_ref", owner, 1);
    wait_slot(226);
    chk("stb_226", stb, 1);
    @(negedge clk);
    chk("wrap_hpos", hpos, 0);
    chk("wrap_stb", stb, 0);
    cnt = 0;
    repeat (227) begin if (cg) cnt++; @(negedge clk); end
    chk("cpu_line_count", cnt, 223);
    dmacon = 11'h3FF; dsk_req = 1; aud_req = 4'hF; cop_req = 1; blt_req = 1;
    wait_slot(0);
    for (int i = 0; i < 12; i++) lit("full", lh[i], lo[i], lx[i]);
    bpu = 3'd4;
    wait_slot(0);
    lit("bpu4_p6", 58, 6, 0);
    lit("bpu4_p2", 59, 5, 1);
    lit("bpu4_p5", 62, 6, 0);
    wait_slot(64);
    rst = 1;
    @(negedge clk);
    chk("midrst_hpos", hpos, 0);
    chk("midrst_owner", owner, 0);
    chk("midrst_gnt", {cg, bg, pg}, 0);
    rst = 0;
    dmacon = 11'h240; dsk_req = 0; aud_req = 0; cop_req = 0; bltpri = 0;
    wait_slot(9);
    cnt = 0;
    repeat (40) begin if (cg) cnt++; @(negedge clk); end
    chk("nasty_cpu_share", cnt, 10);
    cnt = 0;
    while (!cg && cnt < 10) begin @(negedge clk); cnt++; end
    chk("nasty_find_cpu", cg, 1);
    repeat (3) begin @(negedge clk); chk("nasty_blt", owner, 7); end
    @(negedge clk);
    chk("nasty_cpu", owner, 8);
    bltpri = 1;
    wait_slot(0);
    cnt = 0; bcnt = 0;
    repeat (227) begin if (cg) cnt++; if (bg) bcnt++; @(negedge clk); end
    chk("bltpri_cpu", cnt, 0);
    chk("bltpri_blt", bcnt, 223);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
